// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: drives the PC into a combinational instruction
// memory, registers the returned word with its address, and presents it to
// decode under a valid/stall handshake. Supports branch redirects and a
// speculative halt that parks fetch until a branch or reset.
module fetch_unit #(
    parameter int unsigned             PC_WIDTH    = 16,
    parameter int unsigned             INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0]  HALT_OPCODE = 16'hEFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    programcounter,
    input  logic [INSTR_WIDTH-1:0] instrin,
    input  logic                   stall,
    input  logic                   branchtaken,
    input  logic [PC_WIDTH-1:0]    branchtarget,
    output logic [INSTR_WIDTH-1:0] instrout,
    output logic [PC_WIDTH-1:0]    pcout,
    output logic                   instrvalid,
    output logic                   halted
);

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0]      pcout_q, pcout_d;
    logic                     valid_q, valid_d;
    logic                     halted_q, halted_d;

    logic                     is_halt_word;
    logic [PC_WIDTH-1:0]      pc_incr;
    logic [PC_WIDTH-1:0]      branch_pc;

    assign is_halt_word = (instrin == HALT_OPCODE);
    // Wraps modulo 2^PC_WIDTH by construction.
    assign pc_incr      = pc_q + PC_WIDTH'(2);
    // Instructions are halfword aligned; drop bit 0 of the redirect address.
    assign branch_pc    = {branchtarget[PC_WIDTH-1:1], 1'b0};

    // Next-state: branch beats stall beats normal fetch/halt handling.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcout_d  = pcout_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        if (branchtaken) begin
            // Redirect inserts a one-cycle bubble; instr/pcout keep last values.
            pc_d     = branch_pc;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            state_d  = StRun;
        end else if (!stall) begin
            unique case (state_q)
                StRun: begin
                    instr_d = instrin;
                    pcout_d = pc_q;
                    valid_d = 1'b1;
                    if (is_halt_word) begin
                        // Present the halt word once, then park with PC frozen.
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_incr;
                    end
                end
                StHalt: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pcout_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcout_q  <= pcout_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign programcounter = pc_q;
    assign instrout       = instr_q;
    assign pcout          = pcout_q;
    assign instrvalid     = valid_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/branch traffic, compared against a behavioural fetch model.
module tb_fetch_unit;

    localparam logic [15:0] HALT = 16'hEFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] programcounter;
    logic [15:0] instrin;
    logic        stall;
    logic        branchtaken;
    logic [15:0] branchtarget;
    logic [15:0] instrout;
    logic [15:0] pcout;
    logic        instrvalid;
    logic        halted;

    // Instruction memory, indexed by halfword address (aliases above 0xFF).
    logic [15:0] mem_a [128];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [15:0] m_pc, m_instr, m_pcout;
    logic        m_valid, m_halted;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .programcounter (programcounter),
        .instrin        (instrin),
        .stall          (stall),
        .branchtaken    (branchtaken),
        .branchtarget   (branchtarget),
        .instrout       (instrout),
        .pcout          (pcout),
        .instrvalid     (instrvalid),
        .halted         (halted)
    );

    assign instrin = mem_a[programcounter[7:1]];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        logic [15:0] w;
        w = mem_a[addr[7:1]];
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0; m_pcout = 16'h0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One clock edge of architectural behaviour.
    task automatic model_edge(input logic s, input logic b, input logic [15:0] t);
        logic [15:0] w;
        if (b) begin
            m_pc = t & 16'hFFFE;
            m_valid = 1'b0;
            m_halted = 1'b0;
        end else if (s) begin
            // everything holds
        end else if (!m_halted) begin
            w = mem_word(m_pc);
            m_instr = w;
            m_pcout = m_pc;
            m_valid = 1'b1;
            if (w == HALT) m_halted = 1'b1;
            else m_pc = 16'((32'(m_pc) + 32'd2) % 32'h10000);
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pc"},     32'(programcounter), 32'(m_pc));
        check({ctx, ".instr"},  32'(instrout),       32'(m_instr));
        check({ctx, ".pcout"},  32'(pcout),          32'(m_pcout));
        check({ctx, ".valid"},  32'(instrvalid),     32'(m_valid));
        check({ctx, ".halted"}, 32'(halted),         32'(m_halted));
    endtask

    task automatic step(input string ctx, input logic s, input logic b, input logic [15:0] t);
        stall = s; branchtaken = b; branchtarget = t;
        @(posedge clk);
        model_edge(s, b, t);
        #1;
        check_all(ctx);
    endtask

    initial begin
        logic [15:0] w;
        int guard;

        // Non-halt random fill, then directed program words.
        for (int i = 0; i < 128; i++) begin
            w = 16'($urandom);
            if (w == HALT) w = 16'h1234;
            mem_a[i] = w;
        end
        mem_a[0] = 16'hF120; mem_a[1] = 16'hF121; mem_a[2] = 16'h93FF; mem_a[3] = 16'h834C;
        mem_a[16'h24 >> 1] = 16'hF110;
        mem_a[16'h36 >> 1] = HALT;

        rst = 1'b1; stall = 1'b0; branchtaken = 1'b0; branchtarget = 16'h0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch from reset.
        for (int i = 0; i < 3; i++) step("t1", 1'b0, 1'b0, 16'h0);
        check("t1.pcout4", 32'(pcout), 32'h4);
        check("t1.instr3", 32'(instrout), 32'h93FF);
        // Stall while pcout=4.
        for (int i = 0; i < 3; i++) step("t2", 1'b1, 1'b0, 16'h0);
        check("t2.pc_held", 32'(programcounter), 32'h6);
        step("t2rel", 1'b0, 1'b0, 16'h0);
        check("t2.instr", 32'(instrout), 32'h834C);

        // Run to 0x1C then branch to 0x24.
        while (m_pc != 16'h1C) step("run", 1'b0, 1'b0, 16'h0);
        step("t3br", 1'b0, 1'b1, 16'h24);
        check("t3.bubble", 32'(instrvalid), 32'h0);
        step("t3", 1'b0, 1'b0, 16'h0);
        check("t3.instr", 32'(instrout), 32'hF110);

        // Run into the halt word at 0x36 and park.
        guard = 0;
        while (!m_halted && guard < 50) begin
            step("t4", 1'b0, 1'b0, 16'h0);
            guard++;
        end
        check("t4.halt_instr", 32'(instrout), 32'(HALT));
        check("t4.halted", 32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) step("t4park", 1'b0, 1'b0, 16'h0);
        check("t4.pc_frozen", 32'(programcounter), 32'h36);
        step("t4br", 1'b0, 1'b1, 16'h0);
        step("t4res", 1'b0, 1'b0, 16'h0);
        check("t4.resume", 32'(pcout), 32'h0);

        // Branch during stall with odd target; branch racing a halt word.
        step("t5", 1'b1, 1'b1, 16'h0B);
        check("t5.pc", 32'(programcounter), 32'hA);
        step("t5run", 1'b0, 1'b1, 16'h36);
        step("brhalt", 1'b0, 1'b1, 16'h10);
        check("brhalt.nohalt", 32'(halted), 32'h0);

        // Wrap at the top of the address space.
        step("t6br", 1'b0, 1'b1, 16'hFFFE);
        step("t6", 1'b0, 1'b0, 16'h0);
        check("t6.pcout", 32'(pcout), 32'hFFFE);
        check("t6.wrap", 32'(programcounter), 32'h0);

        // Sprinkle halt words for the random phase.
        for (int i = 32; i < 128; i++)
            if ($urandom_range(0, 11) == 0 && i != 16'h24 >> 1) mem_a[i] = HALT;

        for (int c = 0; c < 600; c++) begin
            logic s, b;
            logic [15:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
            step("rand", s, b, t);
            if (c == 300) begin
                // Asynchronous reset pulse between edges.
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all("arst");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
